ctrl_issue_unit: RTL and testbench
==================================

# ctrl_issue_unit

Instruction decode and issue controller sitting directly upstream of `CPU_TOP_MODULE`. It accepts 32-bit KGP miniRISC instruction words over a valid/ready handshake and decodes them into the registered control bundle that `CPU_TOP_MODULE` consumes. It sequences loads as a two-cycle operation and halts on illegal encodings. It also maintains an issued-instruction counter.

## Interface
- `CNT_W`, default 16: width of the `issue_cnt` counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous reset, active-low (rst=0 resets).
- `instr_valid` in 1: upstream instruction word valid.
- `instr` in 32: instruction word. `opcode=instr[31:26]`, `funct=instr[3:0]`.
- `instr_ready` out 1: unit can accept an instruction this cycle.
- `RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg` out 1 each: control bits to `CPU_TOP_MODULE`.
- `ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg` out 2 each: control fields to `CPU_TOP_MODULE`.
- `halted` out 1: sticky; set by an illegal instruction.
- `issue_cnt` out CNT_W: number of instructions issued, wrapping.

## Operation
- Idle vector: every control output is 0.
- States: RUN, LW_ADDR, HALT.
- RUN:
  - `instr_ready=1`.
  - Handshake: `instr_valid & instr_ready` at a rising edge.
  - On a handshake, load the decoded vector into the output registers.
  - With no handshake, load the idle vector (bubble).
- Decode table. Fields not listed are 0.
  - opcode 000000, R-type ALU: `ALUSrc=0`.
    - funct 0000 add: `ALUOp=01`.
    - funct 0001 comp: `ALUOp=01`, `CompEnbl=1`.
    - funct 0010 and: `ALUOp=10`.
    - funct 0011 xor: `ALUOp=11`.
    - All four set `RegWrite=1`.
  - opcode 000001, shifts: `ShiftEnbl=1`, `RegWrite=1`.
    - funct 0000 shll: `ShiftType=00`, `ShiftAmntSel=0`.
    - funct 0001 shrl: `ShiftType=01`, `ShiftAmntSel=0`.
    - funct 0010 shra: `ShiftType=10`, `ShiftAmntSel=0`.
    - funct 0100 shllv, 0101 shrlv, 0110 shrav: same `ShiftType` as above, `ShiftAmntSel=1`.
  - opcode 000010 addi: `ALUSrc=1`, `ALUOp=01`, `RegWrite=1`.
  - opcode 000011 compi: addi vector plus `CompEnbl=1`.
  - opcode 000100 lw: `RegDst=01`, `ImmSel=1`, `ALUSrc=1`, `ALUOp=01`, `BranchType=11`, `JumpType=11`, `MemRead=1`, `MemToReg=01`. Issued as two cycles, see LW_ADDR.
  - opcode 000101 sw: `ImmSel=1`, `ALUSrc=1`, `ALUOp=01`, `MemWrite=1`, `RegWrite=0`.
  - Any other opcode, or an unlisted funct under 000000/000001, is illegal.
- lw sequencing:
  - Accepting lw moves RUN to LW_ADDR.
  - Cycle 1: lw vector with `RegWrite=0`, `instr_ready=0`.
  - Then LW_ADDR returns to RUN. Cycle 2: full lw vector with `RegWrite=1`.
  - `instr_ready` returns to 1 in cycle 2, so the next instruction's vector appears in cycle 3.
- Illegal instruction: an accepted illegal word moves the unit to HALT.
  - Outputs take the idle vector, `halted=1`, `instr_ready=0`.
  - The unit stays in HALT until reset.
- `issue_cnt`:
  - Increments by 1 on every accepted legal instruction (lw counts once).
  - Wraps from 2^CNT_W-1 to 0.
  - Illegal words are not counted.

## Timing
- Reset (rst=0) acts immediately, independent of clk:
  - State=RUN.
  - All controls take the idle vector.
  - `halted=0`, `issue_cnt=0`.
  - `instr_ready=0` while rst=0.
  - An lw in flight when reset asserts is dropped and no second cycle occurs.
- `instr_ready` is combinational from state, =1 only in RUN with rst=1.
- Latency: an instruction accepted at edge N drives controls during the cycle after edge N, i.e. from edge N until edge N+1.
- Throughput:
  - Non-load instructions: 1 per cycle.
  - lw: occupies 2 output cycles.
- A `instr_valid` that stays high through LW_ADDR is not consumed. The same word is accepted at the first edge after ready returns.
- `instr` is sampled only at the handshake edge. Changes on other cycles have no effect.

## Test plan
- Reset release, then `instr_valid=0` for 3 cycles:
  - Controls stay at the idle vector, `instr_ready=1`, `issue_cnt=0`.
- Back-to-back addi (opcode 000010), add (000000/0000), compi (000011), xor (000000/0011):
  - Four consecutive vectors: `ALUSrc` 1,0,1,0; `CompEnbl` 0,0,1,0; `ALUOp` 01,01,01,11.
  - `issue_cnt=4`.
- lw followed by sw held valid:
  - Cycle 1: `MemRead=1`, `RegWrite=0`, `instr_ready=0`.
  - Cycle 2: `RegWrite=1`, `MemToReg=01`, `RegDst=01`.
  - Cycle 3: `MemWrite=1`, `RegWrite=0`.
  - `issue_cnt=2`.
- Illegal opcode 111111 after addi:
  - The addi vector, then the idle vector with `halted=1` and `instr_ready=0`.
  - Further valid words are ignored.
  - `issue_cnt` stays at 1 until rst pulses low.
- Assert rst=0 mid-cycle during LW_ADDR:
  - Outputs go to the idle vector before the next edge.
  - After release, no `RegWrite=1` lw cycle appears, `issue_cnt=0`.
- With CNT_W=4, issue 17 addi:
  - `issue_cnt` reads 15 after 15 instructions, 0 after 16, 1 after 17.

Source files
------------

// File: rtl/ctrl_issue_unit.sv
// ctrl_issue_unit
// Decodes KGP miniRISC instruction words into the registered control bundle
// used by the CPU datapath. Loads are issued as a two-cycle sequence: an
// address phase with RegWrite held low, then a write-back phase. An illegal
// encoding parks the unit in HALT until reset. issue_cnt counts every
// accepted legal instruction and wraps.
module ctrl_issue_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic             RegWrite,
    output logic             ImmSel,
    output logic             ALUSrc,
    output logic             CompEnbl,
    output logic             ShiftAmntSel,
    output logic             ShiftEnbl,
    output logic             ShortBr,
    output logic             LongBr,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             BranchReg,
    output logic [1:0]       ALUOp,
    output logic [1:0]       RegDst,
    output logic [1:0]       ShiftType,
    output logic [1:0]       BranchType,
    output logic [1:0]       JumpType,
    output logic [1:0]       MemToReg,
    output logic             halted,
    output logic [CNT_W-1:0] issue_cnt
);

    // Full control bundle; an all-zero value is the idle (bubble) vector.
    typedef struct packed {
        logic       regWrite;
        logic       immSel;
        logic       aluSrc;
        logic       compEnbl;
        logic       shiftAmntSel;
        logic       shiftEnbl;
        logic       shortBr;
        logic       longBr;
        logic       memRead;
        logic       memWrite;
        logic       branchReg;
        logic [1:0] aluOp;
        logic [1:0] regDst;
        logic [1:0] shiftType;
        logic [1:0] branchType;
        logic [1:0] jumpType;
        logic [1:0] memToReg;
    } ctrlVec_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LW_ADDR = 2'd1,
        HALT    = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SHIFT = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_COMPI = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b000101;

    state_t           stateReg;
    ctrlVec_t         ctrlReg;
    logic             haltedReg;
    logic [CNT_W-1:0] cntReg;

    ctrlVec_t         decVec;
    logic             decLegal;
    logic             decIsLw;

    logic [5:0]       opcode;
    logic [3:0]       funct;
    logic             handshake;
    logic             unusedInstrBits;

    assign opcode          = instr[31:26];
    assign funct           = instr[3:0];
    // Operand/immediate fields are consumed by the datapath, not by this unit.
    assign unusedInstrBits = ^instr[25:4];

    // The load vector; the address phase differs only in RegWrite.
    function automatic ctrlVec_t lwVector(input logic regWr);
        ctrlVec_t v;
        v            = '0;
        v.regWrite   = regWr;
        v.regDst     = 2'b01;
        v.immSel     = 1'b1;
        v.aluSrc     = 1'b1;
        v.aluOp      = 2'b01;
        v.branchType = 2'b11;
        v.jumpType   = 2'b11;
        v.memRead    = 1'b1;
        v.memToReg   = 2'b01;
        return v;
    endfunction

    // Ready depends on reset too, so nothing is offered while rst is low.
    assign instr_ready = rst && (stateReg == RUN);
    assign handshake   = instr_valid && instr_ready;

    // Decode the presented word into a control vector plus legality flags.
    always_comb begin
        decVec   = '0;
        decLegal = 1'b0;
        decIsLw  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                // Only funct 0000..0011 are defined ALU operations.
                if (funct[3:2] == 2'b00) begin
                    decLegal        = 1'b1;
                    decVec.regWrite = 1'b1;
                    decVec.aluSrc   = 1'b0;
                    case (funct[1:0])
                        2'b00:   decVec.aluOp = 2'b01;
                        2'b01: begin
                            decVec.aluOp    = 2'b01;
                            decVec.compEnbl = 1'b1;
                        end
                        2'b10:   decVec.aluOp = 2'b10;
                        default: decVec.aluOp = 2'b11;
                    endcase
                end
            end
            OP_SHIFT: begin
                // funct[2] selects variable shift amount, funct[1:0] the kind;
                // kind 11 and anything with funct[3] set are undefined.
                if (!funct[3] && (funct[1:0] != 2'b11)) begin
                    decLegal            = 1'b1;
                    decVec.regWrite     = 1'b1;
                    decVec.shiftEnbl    = 1'b1;
                    decVec.shiftType    = funct[1:0];
                    decVec.shiftAmntSel = funct[2];
                end
            end
            OP_ADDI, OP_COMPI: begin
                decLegal        = 1'b1;
                decVec.regWrite = 1'b1;
                decVec.aluSrc   = 1'b1;
                decVec.aluOp    = 2'b01;
                decVec.compEnbl = (opcode == OP_COMPI);
            end
            OP_LW: begin
                decLegal = 1'b1;
                decIsLw  = 1'b1;
                // First output cycle is the address phase, no write-back yet.
                decVec   = lwVector(1'b0);
            end
            OP_SW: begin
                decLegal        = 1'b1;
                decVec.immSel   = 1'b1;
                decVec.aluSrc   = 1'b1;
                decVec.aluOp    = 2'b01;
                decVec.memWrite = 1'b1;
            end
            default: begin
                decLegal = 1'b0;
            end
        endcase
    end

    // Issue sequencer: state, registered control bundle, halt flag, counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg  <= RUN;
            ctrlReg   <= '0;
            haltedReg <= 1'b0;
            cntReg    <= '0;
        end else begin
            case (stateReg)
                RUN: begin
                    if (handshake) begin
                        if (decLegal) begin
                            ctrlReg  <= decVec;
                            cntReg   <= cntReg + 1'b1;
                            stateReg <= decIsLw ? LW_ADDR : RUN;
                        end else begin
                            ctrlReg   <= '0;
                            haltedReg <= 1'b1;
                            stateReg  <= HALT;
                        end
                    end else begin
                        ctrlReg <= '0;
                    end
                end
                LW_ADDR: begin
                    // Write-back phase; the load was already counted.
                    ctrlReg  <= lwVector(1'b1);
                    stateReg <= RUN;
                end
                HALT: begin
                    ctrlReg <= '0;
                end
                default: begin
                    ctrlReg  <= '0;
                    stateReg <= RUN;
                end
            endcase
        end
    end

    assign RegWrite     = ctrlReg.regWrite;
    assign ImmSel       = ctrlReg.immSel;
    assign ALUSrc       = ctrlReg.aluSrc;
    assign CompEnbl     = ctrlReg.compEnbl;
    assign ShiftAmntSel = ctrlReg.shiftAmntSel;
    assign ShiftEnbl    = ctrlReg.shiftEnbl;
    assign ShortBr      = ctrlReg.shortBr;
    assign LongBr       = ctrlReg.longBr;
    assign MemRead      = ctrlReg.memRead;
    assign MemWrite     = ctrlReg.memWrite;
    assign BranchReg    = ctrlReg.branchReg;
    assign ALUOp        = ctrlReg.aluOp;
    assign RegDst       = ctrlReg.regDst;
    assign ShiftType    = ctrlReg.shiftType;
    assign BranchType   = ctrlReg.branchType;
    assign JumpType     = ctrlReg.jumpType;
    assign MemToReg     = ctrlReg.memToReg;
    assign halted       = haltedReg;
    assign issue_cnt    = cntReg;

endmodule

// File: tb/tb_ctrl_issue_unit.sv
// Directed testbench for ctrl_issue_unit (instantiated with a 4-bit counter
// so that wrap-around is reachable quickly).
module tb_ctrl_issue_unit;

    localparam int CNT_W = 4;

    // Expected control vectors, packed as
    // {RW,IS,AS,CE,SAS,SE,SB,LB,MR,MW,BR, ALUOp,RegDst,ShiftType,BranchType,JumpType,MemToReg}
    localparam logic [22:0] V_IDLE  = 23'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_00_00_00;
    localparam logic [22:0] V_ADDI  = 23'b1_0_1_0_0_0_0_0_0_0_0_01_00_00_00_00_00;
    localparam logic [22:0] V_ADD   = 23'b1_0_0_0_0_0_0_0_0_0_0_01_00_00_00_00_00;
    localparam logic [22:0] V_COMPI = 23'b1_0_1_1_0_0_0_0_0_0_0_01_00_00_00_00_00;
    localparam logic [22:0] V_XOR   = 23'b1_0_0_0_0_0_0_0_0_0_0_11_00_00_00_00_00;
    localparam logic [22:0] V_AND   = 23'b1_0_0_0_0_0_0_0_0_0_0_10_00_00_00_00_00;
    localparam logic [22:0] V_SHLL  = 23'b1_0_0_0_0_1_0_0_0_0_0_00_00_00_00_00_00;
    localparam logic [22:0] V_SHRAV = 23'b1_0_0_0_1_1_0_0_0_0_0_00_00_10_00_00_00;
    localparam logic [22:0] V_LW1   = 23'b0_1_1_0_0_0_0_0_1_0_0_01_01_00_11_11_01;
    localparam logic [22:0] V_LW2   = 23'b1_1_1_0_0_0_0_0_1_0_0_01_01_00_11_11_01;
    localparam logic [22:0] V_SW    = 23'b0_1_1_0_0_0_0_0_0_1_0_01_00_00_00_00_00;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             instr_valid = 1'b0;
    logic [31:0]      instr = 32'h0;
    logic             instr_ready;
    logic             RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl;
    logic             ShortBr, LongBr, MemRead, MemWrite, BranchReg;
    logic [1:0]       ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg;
    logic             halted;
    logic [CNT_W-1:0] issue_cnt;
    logic [22:0]      obsCtrl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign obsCtrl = {RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl,
                      ShortBr, LongBr, MemRead, MemWrite, BranchReg,
                      ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg};

    ctrl_issue_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .RegWrite     (RegWrite),
        .ImmSel       (ImmSel),
        .ALUSrc       (ALUSrc),
        .CompEnbl     (CompEnbl),
        .ShiftAmntSel (ShiftAmntSel),
        .ShiftEnbl    (ShiftEnbl),
        .ShortBr      (ShortBr),
        .LongBr       (LongBr),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .BranchReg    (BranchReg),
        .ALUOp        (ALUOp),
        .RegDst       (RegDst),
        .ShiftType    (ShiftType),
        .BranchType   (BranchType),
        .JumpType     (JumpType),
        .MemToReg     (MemToReg),
        .halted       (halted),
        .issue_cnt    (issue_cnt)
    );

    // Build an instruction word; the middle bits are non-zero filler that
    // the decoder must ignore.
    function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [3:0] fn);
        return {op, 22'h2A5A5, fn};
    endfunction

    // Pulse reset low across one edge; returns 1 ns after an edge with rst=1.
    task automatic doReset;
        @(posedge clk); #1;
        rst = 1'b0;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        instr_valid = 1'b0;
        #2;
        checks++; if (obsCtrl !== V_IDLE) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", obsCtrl, V_IDLE); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", instr_ready); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (issue_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", issue_cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            $display("idle cycle %0d: ctrl=%h ready=%b cnt=%0d", i, obsCtrl, instr_ready, issue_cnt);
            checks++; if (obsCtrl !== V_IDLE) begin errors++; $display("FAIL idle_ctrl[%0d]: got %h expected %h", i, obsCtrl, V_IDLE); end
            checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL idle_ready[%0d]: got %b expected 1", i, instr_ready); end
            checks++; if (issue_cnt !== 4'd0) begin errors++; $display("FAIL idle_cnt[%0d]: got %0d expected 0", i, issue_cnt); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [4];
        logic [22:0] expv  [4];
        words[0] = mkInstr(6'b000010, 4'b0000); expv[0] = V_ADDI;
        words[1] = mkInstr(6'b000000, 4'b0000); expv[1] = V_ADD;
        words[2] = mkInstr(6'b000011, 4'b0000); expv[2] = V_COMPI;
        words[3] = mkInstr(6'b000000, 4'b0011); expv[3] = V_XOR;
        doReset();
        instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = words[i];
            @(posedge clk); #1;
            $display("b2b issue %0d: instr=%h ctrl=%h cnt=%0d", i, words[i], obsCtrl, issue_cnt);
            checks++; if (obsCtrl !== expv[i]) begin errors++; $display("FAIL b2b_ctrl[%0d]: got %h expected %h", i, obsCtrl, expv[i]); end
        end
        instr_valid = 1'b0;
        checks++; if (issue_cnt !== 4'd4) begin errors++; $display("FAIL b2b_cnt: got %0d expected 4", issue_cnt); end
        @(posedge clk); #1;
        checks++; if (obsCtrl !== V_IDLE) begin errors++; $display("FAIL b2b_bubble: got %h expected %h", obsCtrl, V_IDLE); end
    endtask

    task automatic test_shift_logic;
        logic [31:0] words [3];
        logic [22:0] expv  [3];
        words[0] = mkInstr(6'b000001, 4'b0000); expv[0] = V_SHLL;
        words[1] = mkInstr(6'b000001, 4'b0110); expv[1] = V_SHRAV;
        words[2] = mkInstr(6'b000000, 4'b0010); expv[2] = V_AND;
        doReset();
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = words[i];
            @(posedge clk); #1;
            $display("shift/logic issue %0d: instr=%h ctrl=%h", i, words[i], obsCtrl);
            checks++; if (obsCtrl !== expv[i]) begin errors++; $display("FAIL shift_ctrl[%0d]: got %h expected %h", i, obsCtrl, expv[i]); end
        end
        instr_valid = 1'b0;
        checks++; if (issue_cnt !== 4'd3) begin errors++; $display("FAIL shift_cnt: got %0d expected 3", issue_cnt); end
    endtask

    task automatic test_lw_sw;
        doReset();
        instr_valid = 1'b1;
        instr = mkInstr(6'b000100, 4'b0000);
        @(posedge clk); #1;
        $display("lw cycle 1: ctrl=%h ready=%b cnt=%0d", obsCtrl, instr_ready, issue_cnt);
        checks++; if (obsCtrl !== V_LW1) begin errors++; $display("FAIL lw1_ctrl: got %h expected %h", obsCtrl, V_LW1); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL lw1_ready: got %b expected 0", instr_ready); end
        checks++; if (issue_cnt !== 4'd1) begin errors++; $display("FAIL lw1_cnt: got %0d expected 1", issue_cnt); end
        instr = mkInstr(6'b000101, 4'b0000);
        @(posedge clk); #1;
        $display("lw cycle 2: ctrl=%h ready=%b cnt=%0d", obsCtrl, instr_ready, issue_cnt);
        checks++; if (obsCtrl !== V_LW2) begin errors++; $display("FAIL lw2_ctrl: got %h expected %h", obsCtrl, V_LW2); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL lw2_ready: got %b expected 1", instr_ready); end
        checks++; if (issue_cnt !== 4'd1) begin errors++; $display("FAIL lw2_cnt: got %0d expected 1", issue_cnt); end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        $display("sw issue: ctrl=%h cnt=%0d", obsCtrl, issue_cnt);
        checks++; if (obsCtrl !== V_SW) begin errors++; $display("FAIL sw_ctrl: got %h expected %h", obsCtrl, V_SW); end
        checks++; if (issue_cnt !== 4'd2) begin errors++; $display("FAIL sw_cnt: got %0d expected 2", issue_cnt); end
        @(posedge clk); #1;
        checks++; if (obsCtrl !== V_IDLE) begin errors++; $display("FAIL sw_after: got %h expected %h", obsCtrl, V_IDLE); end
    endtask

    task automatic test_illegal;
        doReset();
        instr_valid = 1'b1;
        instr = mkInstr(6'b000010, 4'b0000);
        @(posedge clk); #1;
        checks++; if (obsCtrl !== V_ADDI) begin errors++; $display("FAIL ill_addi: got %h expected %h", obsCtrl, V_ADDI); end
        instr = mkInstr(6'b111111, 4'b0000);
        @(posedge clk); #1;
        $display("illegal issue: ctrl=%h halted=%b ready=%b cnt=%0d", obsCtrl, halted, instr_ready, issue_cnt);
        checks++; if (obsCtrl !== V_IDLE) begin errors++; $display("FAIL ill_ctrl: got %h expected %h", obsCtrl, V_IDLE); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ill_halted: got %b expected 1", halted); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL ill_ready: got %b expected 0", instr_ready); end
        checks++; if (issue_cnt !== 4'd1) begin errors++; $display("FAIL ill_cnt: got %0d expected 1", issue_cnt); end
        instr = mkInstr(6'b000010, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (obsCtrl !== V_IDLE) begin errors++; $display("FAIL halt_ctrl[%0d]: got %h expected %h", i, obsCtrl, V_IDLE); end
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky[%0d]: got %b expected 1", i, halted); end
            checks++; if (issue_cnt !== 4'd1) begin errors++; $display("FAIL halt_cnt[%0d]: got %0d expected 1", i, issue_cnt); end
        end
        instr_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b expected 0", halted); end
        checks++; if (issue_cnt !== 4'd0) begin errors++; $display("FAIL halt_cnt_clear: got %0d expected 0", issue_cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        // Unlisted funct under the shift opcode is also illegal.
        instr_valid = 1'b1;
        instr = mkInstr(6'b000001, 4'b0011);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        $display("illegal funct issue: halted=%b cnt=%0d", halted, issue_cnt);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ill_funct_halted: got %b expected 1", halted); end
        checks++; if (issue_cnt !== 4'd0) begin errors++; $display("FAIL ill_funct_cnt: got %0d expected 0", issue_cnt); end
    endtask

    task automatic test_reset_during_lw;
        doReset();
        instr_valid = 1'b1;
        instr = mkInstr(6'b000100, 4'b0000);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checks++; if (obsCtrl !== V_LW1) begin errors++; $display("FAIL rlw_lw1: got %h expected %h", obsCtrl, V_LW1); end
        #2;
        rst = 1'b0;
        #1;
        $display("reset mid-lw: ctrl=%h ready=%b cnt=%0d", obsCtrl, instr_ready, issue_cnt);
        checks++; if (obsCtrl !== V_IDLE) begin errors++; $display("FAIL rlw_ctrl: got %h expected %h", obsCtrl, V_IDLE); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rlw_ready: got %b expected 0", instr_ready); end
        checks++; if (issue_cnt !== 4'd0) begin errors++; $display("FAIL rlw_cnt: got %0d expected 0", issue_cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (obsCtrl !== V_IDLE) begin errors++; $display("FAIL rlw_after[%0d]: got %h expected %h", i, obsCtrl, V_IDLE); end
            checks++; if (issue_cnt !== 4'd0) begin errors++; $display("FAIL rlw_after_cnt[%0d]: got %0d expected 0", i, issue_cnt); end
        end
    endtask

    task automatic test_wrap;
        logic [CNT_W-1:0] expCnt;
        doReset();
        instr_valid = 1'b1;
        instr = mkInstr(6'b000010, 4'b0000);
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk); #1;
            expCnt = CNT_W'(i % 16);
            $display("wrap issue %0d: cnt=%0d", i, issue_cnt);
            checks++; if (issue_cnt !== expCnt) begin errors++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", i, issue_cnt, expCnt); end
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_shift_logic();
        test_lw_sw();
        test_illegal();
        test_reset_during_lw();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
